shared_data_memory: RTL and testbench
=====================================

Name: shared_data_memory

Overview:
- Parametrised, multi-requester data memory shared by NUM_CORES matrix-multiply cores.
- Single physical storage array; one access per cycle.
- Round-robin arbitration across cores; registered, one-cycle read data with a per-core valid strobe.
- Replaces the single-port combinational-read data memory for multicore builds.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, address width per core port.
- DEPTH, 1024, number of words; valid addresses are 0..DEPTH-1.
- NUM_CORES, 4, number of requester ports (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_CORES  per-core access request; bit i = core i.
- we  in  NUM_CORES  per-core write enable (1 = write, 0 = read); qualified by req.
- addr  in  NUM_CORES*ADDR_W  flattened addresses; core i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  flattened write data; core i at [i*DATA_W +: DATA_W].
- gnt  out  NUM_CORES  combinational one-hot grant; at most one bit set.
- rvalid  out  NUM_CORES  registered one-hot read-data-valid strobe.
- rdata  out  DATA_W  registered read data, shared bus, qualified by rvalid.
- addr_err  out  1  registered one-cycle pulse: previous granted access had addr >= DEPTH.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - rr_ptr <= 0; rvalid <= 0; rdata <= 0; addr_err <= 0.
  - gnt forced to 0 while rst_n=0, so no access and no write occur in a reset cycle.
  - Memory contents are not reset; contents are undefined after power-up.
- Arbitration, combinational, same cycle:
  - Search req starting at index rr_ptr, upward modulo NUM_CORES.
  - The first set bit k gets gnt[k]=1.
  - No req set gives gnt=0.
- Pointer update at the edge:
  - If any grant, rr_ptr <= (k+1) mod NUM_CORES.
  - Otherwise rr_ptr is unchanged.
- Handshake:
  - A core holds req, we, addr and wdata stable until it sees gnt high.
  - The access completes at the rising edge where gnt[k]=1.
  - The core may drop or change req in the following cycle.
  - An ungranted request is simply retried; no state is held for it.
- Write (granted, we[k]=1):
  - memory[addr_k] <= wdata_k at the edge.
  - rvalid stays 0 in the next cycle.
- Read (granted, we[k]=0):
  - At the edge, rdata <= memory[addr_k] and rvalid <= one-hot(k).
  - Latency is exactly 1 cycle from grant.
  - rdata holds its value until the next granted read; rvalid is a single-cycle pulse unless the next cycle also grants a read.
- Back-to-back: one access per cycle and no bubbles. A read in cycle n+1 to an address written in cycle n returns the new data.
- Out-of-range (addr_k >= DEPTH, compared at full ADDR_W width):
  - The access is still granted and rr_ptr advances.
  - A write is dropped.
  - A read returns rdata=0 with rvalid asserted.
  - addr_err pulses 1 in the next cycle.
  - There is no wrap or aliasing.
- NUM_CORES=1: degenerates to gnt=req, rr_ptr stays 0.
- Reset mid-operation:
  - A read granted in the cycle before reset still produces its rvalid in the reset cycle's output register only if rst_n was high at that edge.
  - Any rvalid pending at a reset edge is cleared.
- Width rules: only the low clog2(DEPTH) address bits index the array; upper bits are used only for the range check.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, rvalid=0, rdata=0, addr_err=0; no memory change.
- Single core write/read: core2 writes addr 5 = 16'h00AA, then reads addr 5 -> gnt=4'b0100 each cycle; one cycle after the read grant, rvalid=4'b0100 and rdata=16'h00AA.
- Round-robin fairness: all four cores request continuously, rr_ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001; each core gets exactly 1 of 4 grants.
- Skip of idle cores: with rr_ptr=1, req=4'b1001 -> gnt=4'b1000, then rr_ptr=0 and gnt=4'b0001.
- Write-then-read hazard: core0 writes addr 999 = 16'h0001 in cycle n, core1 reads addr 999 in cycle n+1 -> rdata=16'h0001 with rvalid=4'b0010 at n+2.
- Out-of-range with reset mid-burst: core3 writes addr 1024 = 16'hFFFF -> addr_err=1 next cycle and a read of addr 0 is unchanged. Core3 reads addr 2000 -> rdata=0, rvalid=4'b1000, addr_err=1. Then assert rst_n=0 while core0 reads -> rvalid=0 and rr_ptr=0 after that edge.

Source files
------------

// File: rtl/shared_data_memory_if.sv
// rtl/shared_data_memory_if.sv - multi-core request/response bundle for the shared data memory
interface shared_data_memory_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        addr_err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, addr_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, addr_err
    );
endinterface

// File: rtl/shared_data_memory.sv
// rtl/shared_data_memory.sv - round-robin arbitrated single-array data memory shared by several cores
module shared_data_memory #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int NUM_CORES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_data_memory_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]    mem [DEPTH];

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 addr_err_q, addr_err_d;

    logic [NUM_CORES-1:0] gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 any_gnt;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [IDX_W-1:0]     mem_idx;
    logic                 in_range;
    int                   cand;

    // Search starts at rr_ptr and wraps; grants are suppressed during reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (j == cand && rst_n && !any_gnt && bus.req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = PTR_W'(j);
                    any_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (gnt[j]) begin
                sel_we    = sel_we | bus.we[j];
                sel_addr  = sel_addr | bus.addr[j*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | bus.wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Range check uses the full address so out-of-range accesses never alias.
    assign in_range = ({1'b0, sel_addr} < DEPTH_EXT);
    assign mem_idx  = sel_addr[IDX_W-1:0];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
        if (any_gnt) begin
            rr_ptr_d   = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + PTR_W'(1);
            addr_err_d = !in_range;
            if (!sel_we) begin
                rvalid_d = gnt;
                rdata_d  = in_range ? mem[mem_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (any_gnt && sel_we && in_range) begin
            mem[mem_idx] <= sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_shared_data_memory.sv
// tb/tb_shared_data_memory.sv - directed stimulus with scoreboard-checked read/error responses
module tb_shared_data_memory;
    typedef struct packed {
        logic [3:0]  v;
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t none = '0;

    shared_data_memory_if #(.DATA_W(16), .ADDR_W(16), .NUM_CORES(4)) bus ();

    shared_data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .NUM_CORES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every rvalid or addr_err event must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.rvalid != 4'b0 || bus.addr_err == 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp rvalid=%b rdata=%h addr_err=%b required none", bus.rvalid, bus.rdata, bus.addr_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rvalid !== e.v || bus.addr_err !== e.e || (e.v != 4'b0 && bus.rdata !== e.d)) begin
                    errors++;
                    $display("FAIL resp rvalid=%b rdata=%h addr_err=%b required rvalid=%b rdata=%h addr_err=%b",
                             bus.rvalid, bus.rdata, bus.addr_err, e.v, e.d, e.e);
                end
            end
        end
    end

    task automatic drive(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.we[i]             = w;
        bus.addr[i*16 +: 16]  = a;
        bus.wdata[i*16 +: 16] = d;
    endtask

    task automatic cyc(input string name, input logic [3:0] eg, input bit push, input exp_t e);
        @(negedge clk);
        checks++;
        if (bus.gnt !== eg) begin
            errors++;
            $display("FAIL gnt_%s got=%b required=%b", name, bus.gnt, eg);
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = 4'b1111;
        bus.we    = 4'b0000;
        bus.addr  = '0;
        bus.wdata = '0;
        rst_n     = 1'b0;

        cyc("reset0", 4'b0000, 0, none);
        cyc("reset1", 4'b0000, 0, none);
        checks++;
        if (bus.rvalid !== 4'b0 || bus.rdata !== 16'h0 || bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rvalid=%b rdata=%h addr_err=%b required 0 0 0", bus.rvalid, bus.rdata, bus.addr_err);
        end
        rst_n = 1'b1;

        // Single core write then read; rr_ptr ends at 3.
        bus.req = 4'b0100;
        drive(2, 1'b1, 16'd5, 16'h00AA);
        cyc("c2_wr", 4'b0100, 0, none);
        drive(2, 1'b0, 16'd5, 16'h0000);
        cyc("c2_rd", 4'b0100, 1, '{v: 4'b0100, d: 16'h00AA, e: 1'b0});

        // Core3 writes addr 0 so later reads of it are defined; rr_ptr wraps to 0.
        bus.req = 4'b1000;
        drive(3, 1'b1, 16'd0, 16'h1234);
        cyc("c3_wr0", 4'b1000, 0, none);

        // All cores read continuously.
        drive(0, 1'b0, 16'd0, 16'h0);
        drive(1, 1'b0, 16'd5, 16'h0);
        drive(2, 1'b0, 16'd5, 16'h0);
        drive(3, 1'b0, 16'd0, 16'h0);
        bus.req = 4'b1111;
        cyc("rr0", 4'b0001, 1, '{v: 4'b0001, d: 16'h1234, e: 1'b0});
        cyc("rr1", 4'b0010, 1, '{v: 4'b0010, d: 16'h00AA, e: 1'b0});
        cyc("rr2", 4'b0100, 1, '{v: 4'b0100, d: 16'h00AA, e: 1'b0});
        cyc("rr3", 4'b1000, 1, '{v: 4'b1000, d: 16'h1234, e: 1'b0});
        cyc("rr4", 4'b0001, 1, '{v: 4'b0001, d: 16'h1234, e: 1'b0});

        // rr_ptr=1, idle cores 1 and 2 are skipped.
        bus.req = 4'b1001;
        cyc("skip0", 4'b1000, 1, '{v: 4'b1000, d: 16'h1234, e: 1'b0});
        cyc("skip1", 4'b0001, 1, '{v: 4'b0001, d: 16'h1234, e: 1'b0});

        // Write-then-read hazard at addr 999.
        bus.req = 4'b0001;
        drive(0, 1'b1, 16'd999, 16'h0001);
        cyc("haz_wr", 4'b0001, 0, none);
        bus.req = 4'b0010;
        drive(1, 1'b0, 16'd999, 16'h0);
        cyc("haz_rd", 4'b0010, 1, '{v: 4'b0010, d: 16'h0001, e: 1'b0});

        // Out-of-range write is dropped (addr 0 keeps its value), out-of-range read returns 0.
        bus.req = 4'b1000;
        drive(3, 1'b1, 16'd1024, 16'hFFFF);
        cyc("oor_wr", 4'b1000, 1, '{v: 4'b0000, d: 16'h0000, e: 1'b1});
        bus.req = 4'b0001;
        drive(0, 1'b0, 16'd0, 16'h0);
        cyc("rd0", 4'b0001, 1, '{v: 4'b0001, d: 16'h1234, e: 1'b0});
        bus.req = 4'b1000;
        drive(3, 1'b0, 16'd2000, 16'h0);
        cyc("oor_rd", 4'b1000, 1, '{v: 4'b1000, d: 16'h0000, e: 1'b1});

        // A read granted just before reset still reports; reset then clears state and rr_ptr.
        bus.req = 4'b0010;
        drive(1, 1'b0, 16'd5, 16'h0);
        cyc("pre_rst", 4'b0010, 1, '{v: 4'b0010, d: 16'h00AA, e: 1'b0});
        rst_n   = 1'b0;
        bus.req = 4'b0001;
        cyc("in_rst", 4'b0000, 0, none);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        cyc("post_rst", 4'b0001, 1, '{v: 4'b0001, d: 16'h1234, e: 1'b0});
        bus.req = 4'b0000;
        cyc("idle0", 4'b0000, 0, none);
        cyc("idle1", 4'b0000, 0, none);
        cyc("idle2", 4'b0000, 0, none);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_resp outstanding=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
